// File: rtl/ram_fifo_ctrl_if.sv
// Ready/valid push and pop ports of the RAM-backed FIFO.
// The controller takes the slave side; the producer/consumer side takes master.
interface ram_fifo_ctrl_if #(
    parameter int data_width = 32
);
    logic                  wr_valid;
    logic [data_width-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [data_width-1:0] rd_data;
    logic                  rd_ready;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a single-port synchronous RAM. Reads prefetch into a
// 2-entry output buffer and take priority over pushes on the shared port.
module ram_fifo_ctrl #(
    parameter int data_width = 32,
    parameter int addr_width = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_fifo_ctrl_if.slave        fifo,
    output logic [addr_width+1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_en,
    output logic                  ram_wr_rdn,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_data_wr,
    input  logic [data_width-1:0] ram_data_rd
);
    localparam int DEPTH = 2 ** addr_width;

    typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE} port_op_e;

    logic [addr_width-1:0]       wptr, rptr, addr_q;
    logic [addr_width:0]         ram_cnt;
    logic                        inflight;
    logic [1:0][data_width-1:0]  ob;
    logic [1:0]                  ob_cnt;
    logic [data_width-1:0]       wdata_q;
    port_op_e                    op;
    logic                        pop;

    // Port decision uses registered state only, so wr_ready never sees rd_ready.
    always_comb begin
        op = OP_IDLE;
        if (ram_cnt != '0 && (ob_cnt + {1'b0, inflight}) < 2'd2)
            op = OP_READ;
        else if (fifo.wr_valid && !full)
            op = OP_WRITE;
    end

    assign full          = (ram_cnt == (addr_width+1)'(DEPTH));
    assign count         = (addr_width+2)'(ram_cnt) + (addr_width+2)'(ob_cnt)
                         + (addr_width+2)'(inflight);
    assign empty         = (count == '0);
    assign fifo.wr_ready = !full && (op != OP_READ);
    assign fifo.rd_valid = (ob_cnt != 2'd0);
    assign fifo.rd_data  = ob[0];
    assign pop           = fifo.rd_valid && fifo.rd_ready;

    assign ram_en      = (op != OP_IDLE);
    assign ram_wr_rdn  = (op == OP_WRITE);
    assign ram_addr    = (op == OP_READ)  ? rptr :
                         (op == OP_WRITE) ? wptr : addr_q;
    assign ram_data_wr = (op == OP_WRITE) ? fifo.wr_data : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            addr_q   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob       <= '0;
            ob_cnt   <= 2'd0;
            wdata_q  <= '0;
        end else begin
            case (op)
                OP_READ: begin
                    rptr    <= rptr + 1'b1;
                    addr_q  <= rptr;
                    ram_cnt <= ram_cnt - 1'b1;
                end
                OP_WRITE: begin
                    wptr    <= wptr + 1'b1;
                    addr_q  <= wptr;
                    wdata_q <= fifo.wr_data;
                    ram_cnt <= ram_cnt + 1'b1;
                end
                default: ;
            endcase
            inflight <= (op == OP_READ);

            // A read only issues with a free slot, so a landing word never
            // meets a full buffer; pop+land leaves ob_cnt unchanged.
            if (inflight && pop) begin
                if (ob_cnt == 2'd1) begin
                    ob[0] <= ram_data_rd;
                end else begin
                    ob[0] <= ob[1];
                    ob[1] <= ram_data_rd;
                end
            end else if (inflight) begin
                ob[ob_cnt[0]] <= ram_data_rd;
                ob_cnt        <= ob_cnt + 2'd1;
            end else if (pop) begin
                ob[0]  <= ob[1];
                ob_cnt <= ob_cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Random and directed bench for ram_fifo_ctrl against a queue model of the FIFO
// and a behavioural single-port RAM.
module tb_ram_fifo_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW+1:0] count;
    logic          full, empty, ram_en, ram_wr_rdn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_wr, ram_data_rd;

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.data_width(DW)) bus ();

    ram_fifo_ctrl #(.data_width(DW), .addr_width(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo        (bus.slave),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .ram_en      (ram_en),
        .ram_wr_rdn  (ram_wr_rdn),
        .ram_addr    (ram_addr),
        .ram_data_wr (ram_data_wr),
        .ram_data_rd (ram_data_rd)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_rdn) mem[ram_addr] <= ram_data_wr;
            else            ram_data_rd   <= mem[ram_addr];
        end
    end

    int            checks = 0;
    int            failures = 0;
    int            stall = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] outs[$];
    logic [DW-1:0] ins[$];
    logic          obs_rv;
    logic [DW-1:0] obs_rd;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check against the model, commit at posedge.
    task automatic tick(input logic wv, input logic [DW-1:0] wd, input logic rr, output logic acc);
        logic pop, rd_iss;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        #1;
        obs_rv = bus.rd_valid;
        obs_rd = bus.rd_data;
        rd_iss = ram_en && !ram_wr_rdn;
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        if (full) chk("full_count", count >= DEPTH, 1);
        chk("wr_ready_rule", bus.wr_ready, !full && !rd_iss);
        chk("write_issue", ram_en && ram_wr_rdn, wv && bus.wr_ready);
        if (ram_en && ram_wr_rdn) chk("write_data", ram_data_wr, wd);
        if (bus.rd_valid) begin
            if (q.size() == 0) chk("rd_valid_empty", bus.rd_valid, 0);
            else               chk("head", bus.rd_data, q[0]);
        end
        if (q.size() > 0 && !bus.rd_valid) stall++;
        else                               stall = 0;
        if (stall > 3) chk("rd_stall", stall, 3);
        acc = wv && bus.wr_ready;
        pop = bus.rd_valid && rr;
        if (pop && q.size() > 0) begin
            outs.push_back(bus.rd_data);
            void'(q.pop_front());
        end
        if (acc) q.push_back(wd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [DW-1:0] wd;
        logic          wv, rr;
        int            nxt, sent;

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_wr_rdn", ram_wr_rdn, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data_wr", ram_data_wr, 0);
        rst = 1'b0;

        // Latency from an empty FIFO: visible three cycles after the push.
        tick(1'b1, 32'h12345678, 1'b0, acc);
        chk("lat_accept", acc, 1);
        tick(1'b0, '0, 1'b0, acc);
        chk("lat_n1", obs_rv, 0);
        tick(1'b0, '0, 1'b0, acc);
        chk("lat_n2", obs_rv, 0);
        tick(1'b0, '0, 1'b0, acc);
        chk("lat_n3", obs_rv, 1);
        chk("lat_data", obs_rd, 32'h12345678);
        tick(1'b0, '0, 1'b1, acc);
        outs.delete();

        // Reset with a read in flight; the stale word must not surface.
        tick(1'b1, 32'hDEADBEEF, 1'b0, acc);
        tick(1'b0, '0, 1'b0, acc);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", bus.rd_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ram_en", ram_en, 0);
        q.delete();
        outs.delete();
        stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 32'hA5A5A5A5, 1'b0, acc);
        for (int c = 0; c < 10 && outs.size() < 1; c++) tick(1'b0, '0, 1'b1, acc);
        chk("post_rst_pops", outs.size(), 1);
        if (outs.size() > 0) chk("post_rst_data", outs[0], 32'hA5A5A5A5);
        outs.delete();

        // Fill with no pops: DEPTH words in RAM plus two in the buffer.
        nxt = 0;
        for (int c = 0; c < 40; c++) begin
            tick(nxt <= 20, DW'(nxt), 1'b0, acc);
            if (acc) nxt++;
        end
        chk("fill_accepted", nxt, DEPTH + 2);
        chk("fill_count", count, DEPTH + 2);
        chk("fill_full", full, 1);
        chk("fill_wr_ready", bus.wr_ready, 0);
        for (int c = 0; c < 40; c++) tick(1'b0, '0, 1'b1, acc);
        chk("drain_pops", outs.size(), DEPTH + 2);
        for (int i = 0; i < outs.size(); i++) chk("drain_order", outs[i], i);
        chk("drain_empty", empty, 1);
        outs.delete();

        // Random push/pop across several pointer wraps.
        sent = 0;
        wd   = $urandom;
        for (int c = 0; c < 2000 && outs.size() < 50; c++) begin
            wv = (sent < 50) && ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            tick(wv, wd, rr, acc);
            if (acc) begin
                ins.push_back(wd);
                sent++;
                wd = $urandom;
            end
        end
        chk("wrap_pops", outs.size(), 50);
        for (int i = 0; i < outs.size() && i < ins.size(); i++) chk("wrap_order", outs[i], ins[i]);
        chk("wrap_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
